// File: rtl/pe_rank_receiver.sv
// pe_rank_receiver: collects a V set of rank entries from UV router packets into a readable buffer
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   arm, rank_no       start a new reception of rank_no entries (sampled on arm)
//   in_valid, in_data  router packet {info, addr, data}; in_rdy is the receiver's ready
//   rd_en, rd_addr     buffer read request; rd_data is valid one cycle later
//   rank_done          one-cycle pulse when the set is complete
//   rank_ready         level while the buffer holds a complete set
//   consume            PE has finished with the set
//   rx_err             sticky protocol error
module pe_rank_receiver #(
    parameter int ROUTER_WIDTH = 36,
    parameter int RANK_WIDTH = 6,
    parameter int DATA_WIDTH = 16,
    parameter logic [3:0] INFO_UV = 4'd3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic [RANK_WIDTH-1:0]   rank_no,
    input  logic                    in_valid,
    input  logic [ROUTER_WIDTH-1:0] in_data,
    output logic                    in_rdy,
    input  logic                    rd_en,
    input  logic [RANK_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rank_done,
    output logic                    rank_ready,
    input  logic                    consume,
    output logic                    rx_err
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RECV = 2'd1;
    localparam logic [1:0] FULL = 2'd2;
    localparam logic [RANK_WIDTH-1:0] ONE = 1;

    logic [1:0]            state;
    logic [RANK_WIDTH-1:0] rx_cnt, exp_reg;
    logic [DATA_WIDTH-1:0] mem [2**RANK_WIDTH];

    logic [3:0]            info;
    logic [15:0]           addr;
    logic [RANK_WIDTH-1:0] idx;
    logic                  arm_ok, acc, in_range, wr, last, err, rel, empty_set;

    assign info = in_data[ROUTER_WIDTH-1 -: 4];
    assign addr = in_data[ROUTER_WIDTH-5 -: 16];
    assign idx = addr[RANK_WIDTH-1:0];
    assign in_rdy = state != FULL;

    always_comb begin
        arm_ok = arm && state == IDLE;
        empty_set = arm_ok && rank_no == '0;
        acc = in_valid && in_rdy && info == INFO_UV;
        in_range = addr[15:RANK_WIDTH] == '0 && idx < exp_reg;
        wr = state == RECV && acc && in_range;
        last = wr && (rx_cnt + ONE) == exp_reg;
        rel = state == FULL && consume;
        // rx_cnt doubles as the expected in-order index: both clear on arm and advance on every counted packet
        err = (arm && state != IDLE) || (state == RECV && acc && (!in_range || idx != rx_cnt));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            rx_cnt <= '0;
            exp_reg <= '0;
            rank_done <= 1'b0;
            rank_ready <= 1'b0;
            rx_err <= 1'b0;
        end else begin
            state <= arm_ok ? (empty_set ? FULL : RECV) : last ? FULL : rel ? IDLE : state;
            exp_reg <= arm_ok ? rank_no : exp_reg;
            rx_cnt <= arm_ok ? '0 : wr ? rx_cnt + ONE : rx_cnt;
            rank_done <= empty_set || last;
            rank_ready <= empty_set || last || (rank_ready && !rel);
            rx_err <= arm_ok ? 1'b0 : rx_err || err;
        end
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[idx] <= in_data[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end
endmodule
